lighthouse_ootx_encoder: RTL and testbench

//  Serialises a lighthouse OOTX frame (preamble, length, payload, CRC32) one bit per sweep-cycle strobe.
//  It is the transmit-side counterpart of the OOTX decoder.

---
 rtl/lighthouse_ootx_encoder.sv | 178 +++++++++++++++++
 tb/tb_lighthouse_ootx_encoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lighthouse_ootx_encoder.sv
// Lighthouse OOTX frame serialiser.
// Computes the CRC32 of a latched payload bit-serially, then emits one frame
// bit per bit strobe: preamble, length word, payload words, two CRC words.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for start; outputs quiet, crc32 holds last result
// S_CRC_CALC | one payload bit per cycle into the CRC; strobes ignored
// S_PREAMBLE | 17 zeros then a one (bit_idx 0..17)
// S_LENGTH   | length word plus sync bit (bit_idx 0..16)
// S_PAYLOAD  | W payload words, each plus sync bit
// S_CRC      | two CRC words, each plus sync bit; last bit ends the frame
module lighthouse_ootx_encoder #(
  parameter int PAYLOAD_BYTES = 33
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [PAYLOAD_BYTES*8-1:0]   payload_i,
  input  logic                         bit_strobe_i,
  output logic                         bit_out_o,
  output logic                         bit_valid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [31:0]                  crc32_o
);

  localparam int          NBITS    = PAYLOAD_BYTES * 8;
  localparam int          W        = (PAYLOAD_BYTES + 1) / 2;
  localparam int          CALC_W   = $clog2(NBITS);
  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [15:0] LEN      = 16'(PAYLOAD_BYTES);
  localparam logic [15:0] LEN_WORD = {LEN[7:0], LEN[15:8]};

  typedef enum logic [2:0] {
    S_IDLE, S_CRC_CALC, S_PREAMBLE, S_LENGTH, S_PAYLOAD, S_CRC
  } state_t;

  state_t              state_q, state_d;
  logic [NBITS-1:0]    payload_q, payload_d;
  logic [31:0]         crc_acc_q, crc_acc_d;
  logic [31:0]         crc32_q, crc32_d;
  logic [CALC_W-1:0]   calc_idx_q, calc_idx_d;
  logic [4:0]          bit_idx_q, bit_idx_d;
  logic [5:0]          word_idx_q, word_idx_d;
  logic                bit_out_q, bit_out_d;
  logic                bit_valid_q, bit_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [W*16-1:0]     payload_pad;
  logic [15:0]         pay_word;
  logic [15:0]         cur_word;
  logic                frame_bit;
  logic                crc_fb;
  logic [31:0]         crc_step;

  // Select the word being sent, derive the current frame bit and the next CRC step.
  always_comb begin
    payload_pad = '0;
    payload_pad[NBITS-1:0] = payload_q;
    pay_word = '0;
    for (int k = 0; k < W; k++) begin
      if (word_idx_q == 6'(k)) pay_word = {payload_pad[16*k +: 8], payload_pad[16*k+8 +: 8]};
    end
    case (state_q)
      S_LENGTH:  cur_word = LEN_WORD;
      S_PAYLOAD: cur_word = pay_word;
      S_CRC:     cur_word = word_idx_q[0] ? {crc32_q[23:16], crc32_q[31:24]}
                                          : {crc32_q[7:0], crc32_q[15:8]};
      default:   cur_word = '0;
    endcase
    if (state_q == S_PREAMBLE) frame_bit = (bit_idx_q == 5'd17);
    else if (bit_idx_q == 5'd16) frame_bit = 1'b1;
    else frame_bit = cur_word[4'd15 - bit_idx_q[3:0]];
    crc_fb   = crc_acc_q[0] ^ payload_q[calc_idx_q];
    crc_step = {1'b0, crc_acc_q[31:1]} ^ (crc_fb ? POLY : 32'h0);
  end

  // Next-state and output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    crc_acc_d   = crc_acc_q;
    crc32_d     = crc32_q;
    calc_idx_d  = calc_idx_q;
    bit_idx_d   = bit_idx_q;
    word_idx_d  = word_idx_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          payload_d  = payload_i;
          crc_acc_d  = 32'hFFFFFFFF;
          crc32_d    = '0;
          calc_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = S_CRC_CALC;
        end
      end
      S_CRC_CALC: begin
        crc_acc_d  = crc_step;
        calc_idx_d = calc_idx_q + CALC_W'(1);
        if (calc_idx_q == CALC_W'(NBITS - 1)) begin
          crc32_d    = ~crc_step;
          bit_idx_d  = '0;
          word_idx_d = '0;
          state_d    = S_PREAMBLE;
        end
      end
      default: begin
        if (bit_strobe_i) begin
          bit_out_d   = frame_bit;
          bit_valid_d = 1'b1;
          bit_idx_d   = bit_idx_q + 5'd1;
          if (state_q == S_PREAMBLE && bit_idx_q == 5'd17) begin
            bit_idx_d = '0;
            state_d   = S_LENGTH;
          end else if (state_q != S_PREAMBLE && bit_idx_q == 5'd16) begin
            bit_idx_d  = '0;
            word_idx_d = word_idx_q + 6'd1;
            if (state_q == S_LENGTH) begin
              word_idx_d = '0;
              state_d    = S_PAYLOAD;
            end else if (state_q == S_PAYLOAD && word_idx_q == 6'(W - 1)) begin
              word_idx_d = '0;
              state_d    = S_CRC;
            end else if (state_q == S_CRC && word_idx_q == 6'd1) begin
              word_idx_d = '0;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              state_d    = S_IDLE;
            end
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      payload_q   <= '0;
      crc_acc_q   <= '0;
      crc32_q     <= '0;
      calc_idx_q  <= '0;
      bit_idx_q   <= '0;
      word_idx_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      crc_acc_q   <= crc_acc_d;
      crc32_q     <= crc32_d;
      calc_idx_q  <= calc_idx_d;
      bit_idx_q   <= bit_idx_d;
      word_idx_q  <= word_idx_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bit_out_o   = bit_out_q;
  assign bit_valid_o = bit_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign crc32_o     = crc32_q;

endmodule

// File: tb/tb_lighthouse_ootx_encoder.sv
// Bench for the OOTX encoder: two instances (9-byte and 33-byte payloads),
// reference frames built from the frame rules with a software CRC32.
module tb_lighthouse_ootx_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start9 = 1'b0, strobe9 = 1'b0;
  logic [71:0] pay9 = '0;
  logic        bo9, bv9, busy9, done9;
  logic [31:0] crc9;

  logic         start33 = 1'b0, strobe33 = 1'b0;
  logic [263:0] pay33 = '0;
  logic         bo33, bv33, busy33, done33;
  logic [31:0]  crc33;

  always #5 clk = ~clk;

  lighthouse_ootx_encoder #(.PAYLOAD_BYTES(9)) dut9 (
    .clock_i(clk), .reset_i(rst), .start_i(start9), .payload_i(pay9),
    .bit_strobe_i(strobe9), .bit_out_o(bo9), .bit_valid_o(bv9),
    .busy_o(busy9), .done_o(done9), .crc32_o(crc9));

  lighthouse_ootx_encoder #(.PAYLOAD_BYTES(33)) dut33 (
    .clock_i(clk), .reset_i(rst), .start_i(start33), .payload_i(pay33),
    .bit_strobe_i(strobe33), .bit_out_o(bo33), .bit_valid_o(bv33),
    .busy_o(busy33), .done_o(done33), .crc32_o(crc33));

  int n_chk = 0;
  int n_fail = 0;
  int sel = 0;
  byte unsigned mb[64];
  int mn = 9;
  bit got[$];
  bit prev[$];
  bit expq[$];
  int strobes;
  bit done_seen;

  typedef struct {
    int          word_no;
    logic [15:0] exp;
  } wvec_t;
  wvec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit o_bo();    return sel ? bo33 : bo9;       endfunction
  function automatic bit o_bv();    return sel ? bv33 : bv9;       endfunction
  function automatic bit o_busy();  return sel ? busy33 : busy9;   endfunction
  function automatic bit o_done();  return sel ? done33 : done9;   endfunction
  function automatic logic [31:0] o_crc(); return sel ? crc33 : crc9; endfunction

  task automatic set_in(input bit s, input bit st);
    if (sel == 0) begin start9 = s; strobe9 = st; end
    else begin start33 = s; strobe33 = st; end
  endtask

  task automatic load_pay();
    if (sel == 0) for (int k = 0; k < 9; k++) pay9[8*k +: 8] = mb[k];
    else for (int k = 0; k < 33; k++) pay33[8*k +: 8] = mb[k];
  endtask

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < mn; i++) begin
      c = c ^ {24'h0, mb[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic ref_frame();
    int words[$];
    logic [31:0] c;
    int lo;
    expq.delete();
    for (int i = 0; i < 17; i++) expq.push_back(1'b0);
    expq.push_back(1'b1);
    words.push_back(((mn & 255) << 8) | ((mn >> 8) & 255));
    for (int k = 0; k < (mn + 1) / 2; k++) begin
      lo = (2 * k + 1 < mn) ? int'(mb[2*k+1]) : 0;
      words.push_back((int'(mb[2*k]) << 8) | lo);
    end
    c = ref_crc();
    words.push_back((int'(c[7:0]) << 8) | int'(c[15:8]));
    words.push_back((int'(c[23:16]) << 8) | int'(c[31:24]));
    foreach (words[i]) begin
      for (int b = 15; b >= 0; b--) expq.push_back(bit'((words[i] >> b) & 1));
      expq.push_back(1'b1);
    end
  endtask

  function automatic logic [15:0] word_at(input int pos);
    logic [15:0] w;
    w = '0;
    for (int b = 0; b < 16; b++) w = {w[14:0], (pos + b < got.size()) ? got[pos+b] : 1'b0};
    return w;
  endfunction

  // Runs one frame: optional start, strobes (periodic or random), optional
  // conflicting start or reset once a given number of bits has been seen.
  task automatic run_frame(input bit do_start, input int spacing, input bit rnd,
                           input int restart_at, input int reset_at, input int budget);
    int cyc;
    bit fin, restarted, st, s, done_bad;
    got.delete();
    strobes = 0; done_seen = 0; cyc = 0; fin = 0; restarted = 0;
    if (do_start) set_in(1'b1, 1'b0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (o_bv()) got.push_back(o_bo());
      if (o_done()) begin
        done_seen = 1; fin = 1;
        chk("busy_low_on_done", o_busy(), 0);
        set_in(1'b0, 1'b1);
        @(negedge clk);
        chk("strobe_on_done_ignored", o_bv(), 0);
        chk("done_one_cycle", o_done(), 0);
        set_in(1'b0, 1'b0);
      end else if (reset_at >= 0 && got.size() == reset_at) begin
        fin = 1;
        rst = 1'b1;
        set_in(1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", o_busy(), 0);
        chk("reset_bit_out", o_bo(), 0);
        chk("reset_bit_valid", o_bv(), 0);
        done_bad = 0;
        repeat (60) begin
          @(negedge clk);
          if (o_done() || o_bv()) done_bad = 1;
        end
        chk("reset_no_done", done_bad, 0);
        set_in(1'b0, 1'b0);
      end else if (cyc > budget) begin
        fin = 1;
        n_chk++; n_fail++;
        $display("FAIL frame_timeout: got %0d bits after %0d cycles, required done", got.size(), cyc);
        set_in(1'b0, 1'b0);
      end
      if (!fin) begin
        st = rnd ? ($urandom_range(0, 2) == 0) : ((cyc % spacing) == 0);
        if (st) strobes++;
        s = 0;
        if (restart_at >= 0 && !restarted && got.size() == restart_at) begin
          pay9 = ~pay9;
          s = 1; restarted = 1;
        end
        set_in(s, st);
      end
    end
  endtask

  task automatic cmp_frame(input string name);
    int nbad;
    ref_frame();
    chk({name, "_done"}, done_seen, 1);
    chk({name, "_nbits"}, got.size(), expq.size());
    nbad = 0;
    for (int i = 0; i < expq.size(); i++) if (i >= got.size() || got[i] != expq[i]) nbad++;
    chk({name, "_bit_errors"}, nbad, 0);
    chk({name, "_crc32"}, o_crc(), ref_crc());
  endtask

  initial begin
    int bad, nz;
    tbl[0] = '{0, 16'h0900}; tbl[1] = '{1, 16'h3132}; tbl[2] = '{2, 16'h3334};
    tbl[3] = '{3, 16'h3536}; tbl[4] = '{4, 16'h3738}; tbl[5] = '{5, 16'h3900};
    tbl[6] = '{6, 16'h2639}; tbl[7] = '{7, 16'hF4CB};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bit_out", bo9, 0);
    chk("rst_bit_valid", bv9, 0);
    chk("rst_busy", busy9, 0);
    chk("rst_done", done9, 0);
    chk("rst_crc32", crc9, 0);
    chk("rst_busy33", busy33, 0);
    rst = 1'b0;

    // CRC check vector with start and strobe together, strobes held through CRC_CALC.
    sel = 0; mn = 9;
    for (int k = 0; k < 9; k++) mb[k] = 8'h31 + 8'(k);
    load_pay();
    @(negedge clk);
    start9 = 1'b1; strobe9 = 1'b1;
    bad = 0;
    @(negedge clk);
    start9 = 1'b0;
    if (bv9) bad++;
    chk("busy_after_start", busy9, 1);
    repeat (71) begin @(negedge clk); if (bv9) bad++; end
    chk("crc_not_before_72", crc9, 0);
    @(negedge clk);
    if (bv9) bad++;
    chk("crc_after_72", crc9, 32'hCBF43926);
    chk("no_bits_in_crc_calc", bad, 0);
    strobe9 = 1'b0;
    run_frame(0, 1, 0, -1, -1, 2000);
    cmp_frame("t2");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_word%0d", tbl[i].word_no), word_at(18 + 17 * tbl[i].word_no), tbl[i].exp);
    end
    chk("crc_persists", crc9, 32'hCBF43926);

    // Same payload, back-to-back start, strobes every 200 cycles.
    prev = got;
    run_frame(1, 200, 0, -1, -1, 40000);
    bad = 0;
    for (int i = 0; i < prev.size(); i++) if (i >= got.size() || got[i] != prev[i]) bad++;
    chk("t5_same_sequence", bad, 0);
    chk("t5_valid_eq_strobes", got.size(), strobes);

    // Conflicting start during PAYLOAD must be ignored.
    for (int k = 0; k < 9; k++) mb[k] = 8'($urandom);
    load_pay();
    run_frame(1, 1, 0, 50, -1, 2000);
    cmp_frame("t4");

    // Reset mid-PAYLOAD, then a fresh full frame.
    for (int k = 0; k < 9; k++) mb[k] = 8'h31 + 8'(k);
    load_pay();
    run_frame(1, 1, 0, -1, 45, 2000);
    run_frame(1, 1, 0, -1, -1, 2000);
    cmp_frame("t1_after_reset");

    // Default size, all-zero payload.
    sel = 1; mn = 33;
    for (int k = 0; k < 64; k++) mb[k] = 8'h00;
    load_pay();
    run_frame(1, 1, 0, -1, -1, 3000);
    cmp_frame("t3");
    chk("t3_total_bits", got.size(), 18 + 17 * (17 + 3));
    nz = 0;
    for (int i = 0; i < 17 && i < got.size(); i++) if (got[i]) nz++;
    chk("t3_preamble_zeros", nz, 0);
    chk("t3_bit17", (got.size() > 17) ? got[17] : 1'b0, 1);
    chk("t3_length_word", word_at(18), 16'h2100);
    bad = 0;
    for (int p = 34; p < 18 + 17 * 20; p += 17) if (p >= got.size() || !got[p]) bad++;
    chk("t3_sync_bits", bad, 0);

    // Random payloads with random strobe timing on both sizes.
    for (int r = 0; r < 3; r++) begin
      sel = 1; mn = 33;
      for (int k = 0; k < 33; k++) mb[k] = 8'($urandom);
      load_pay();
      run_frame(1, 1, 1, -1, -1, 6000);
      cmp_frame($sformatf("rand33_%0d", r));
    end
    for (int r = 0; r < 2; r++) begin
      sel = 0; mn = 9;
      for (int k = 0; k < 9; k++) mb[k] = 8'($urandom);
      load_pay();
      run_frame(1, 1, 1, -1, -1, 3000);
      cmp_frame($sformatf("rand9_%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
